// File: rtl/imem_loader_if.sv
// Bundle between the program loader and its surroundings: load control,
// big-endian byte stream in, instruction-memory write port out.
interface imem_loader_if #(
   parameter int ADDR_WORDS_LOG2 = 8
);
   // Byte stream: a byte moves on a rising clk edge where byte_valid and
   // byte_ready are both high; the source holds byte_data until then.
   logic                       start;
   logic [ADDR_WORDS_LOG2:0]   word_count;
   logic                       byte_valid;
   logic [7:0]                 byte_data;
   logic                       byte_ready;
   logic                       mem_we;
   logic [31:0]                mem_addr;
   logic [31:0]                mem_wdata;
   logic                       cpu_rst;
   logic                       busy;
   logic                       done;
   logic                       err;
   logic [1:0]                 dbg_state;

   modport master (
      output start, word_count, byte_valid, byte_data,
      input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, err,
             dbg_state
   );

   modport slave (
      input  start, word_count, byte_valid, byte_data,
      output byte_ready, mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, err,
             dbg_state
   );
endinterface

// File: rtl/imem_loader.sv
// Program loader: assembles a big-endian byte stream into 32-bit words and
// writes them to instruction memory from address 0, holding the CPU in reset.
module imem_loader #(
   parameter int ADDR_WORDS_LOG2 = 8
) (
   input  logic           clk,
   input  logic           rst,
   imem_loader_if.slave   bus
);
   localparam int AW = ADDR_WORDS_LOG2;
   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RECV  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t      r_state;
   logic [AW:0] r_count;
   logic [AW:0] r_word_idx;
   logic [1:0]  r_byte_idx;
   logic [31:0] r_word;
   logic        r_byte_ready;
   logic        r_mem_we;
   logic        r_busy;
   logic        r_done;
   logic        r_err;

   logic        w_take;
   logic        w_start_ok;
   logic        w_last_word;

   assign w_take      = r_byte_ready & bus.byte_valid;
   assign w_start_ok  = (bus.word_count != '0) && (bus.word_count <= DEPTH);
   assign w_last_word = (r_word_idx == (r_count - ONE));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_count      <= '0;
         r_word_idx   <= '0;
         r_byte_idx   <= '0;
         r_word       <= '0;
         r_byte_ready <= 1'b0;
         r_mem_we     <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_mem_we <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  if (w_start_ok) begin
                     r_count      <= bus.word_count;
                     r_word_idx   <= '0;
                     r_byte_idx   <= '0;
                     r_state      <= S_RECV;
                     r_byte_ready <= 1'b1;
                     r_busy       <= 1'b1;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            S_RECV: begin
               // First byte ends up in the top lane after four shifts.
               if (w_take) begin
                  r_word     <= {r_word[23:0], bus.byte_data};
                  r_byte_idx <= r_byte_idx + 2'd1;
                  if (r_byte_idx == 2'd3) begin
                     r_state      <= S_WRITE;
                     r_byte_ready <= 1'b0;
                     r_mem_we     <= 1'b1;
                  end
               end
            end
            S_WRITE: begin
               r_word_idx <= r_word_idx + ONE;
               if (w_last_word) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_state      <= S_RECV;
                  r_byte_ready <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state      <= S_IDLE;
               r_byte_ready <= 1'b0;
               r_busy       <= 1'b0;
            end
         endcase
      end
   end

   // Address and data come straight from state that is frozen during WRITE.
   assign bus.mem_addr   = {{(29 - AW){1'b0}}, r_word_idx, 2'b00};
   assign bus.mem_wdata  = r_word;
   assign bus.mem_we     = r_mem_we;
   assign bus.byte_ready = r_byte_ready;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.err        = r_err;
   // CPU stays in reset through the system reset and for the whole load.
   assign bus.cpu_rst    = rst | r_busy;
   assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized byte streams and gaps
// compared against a word-list model built directly from the byte order.
module tb_imem_loader;
   localparam int AW    = 2;
   localparam int DEPTH = 1 << AW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   imem_loader_if #(.ADDR_WORDS_LOG2(AW)) bus ();

   imem_loader #(.ADDR_WORDS_LOG2(AW)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0]  tx_q[$];
   logic [63:0] exp_q[$];
   logic [63:0] got_q[$];

   // Monitor: every value below is written only here.
   int cyc        = 0;
   int we_cyc     = 0;
   int done_cyc   = 0;
   int done_cnt   = 0;
   int err_cnt    = 0;
   int ready_in_we = 0;

   always @(negedge clk) begin
      cyc++;
      if (bus.mem_we === 1'b1) begin
         got_q.push_back({bus.mem_addr, bus.mem_wdata});
         we_cyc = cyc;
         if (bus.byte_ready !== 1'b0) ready_in_we++;
      end
      if (bus.done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (bus.err === 1'b1) err_cnt++;
   end

   // Driver tasks
   task automatic start_load(input int wc);
      bus.start      = 1'b1;
      bus.word_count = (AW + 1)'(wc);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic send_bytes(input int first, input int n, input int gap_max,
                             output bit ok);
      bit acc;
      int waited;
      ok = 1'b1;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, gap_max)) begin
            bus.byte_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         bus.byte_valid = 1'b1;
         bus.byte_data  = tx_q[first + i];
         waited = 0;
         do begin
            @(negedge clk);
            acc = bus.byte_ready;
            @(posedge clk);
            #1;
            waited++;
         end while (!acc && waited < 20);
         if (!acc) ok = 1'b0;
      end
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'h00;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic fill_tx(input int nbytes);
      tx_q.delete();
      for (int i = 0; i < nbytes; i++) tx_q.push_back(8'($urandom_range(0, 255)));
   endtask

   // Reference model: word i lives at byte address 4*i, first byte most significant.
   task automatic build_exp(input int wc);
      logic [31:0] a, d;
      exp_q.delete();
      for (int i = 0; i < wc; i++) begin
         a = 32'(i * 4);
         d = (32'(tx_q[4*i]) << 24) + (32'(tx_q[4*i+1]) << 16) +
             (32'(tx_q[4*i+2]) << 8) + 32'(tx_q[4*i+3]);
         exp_q.push_back({a, d});
      end
   endtask

   // Tests
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (bus.byte_ready !== 1'b0) $display("FAIL rst_byte_ready got=%b exp=0", bus.byte_ready); else n_pass++;
      n_checks++; if (bus.mem_we !== 1'b0) $display("FAIL rst_mem_we got=%b exp=0", bus.mem_we); else n_pass++;
      n_checks++; if (bus.mem_addr !== 32'h0) $display("FAIL rst_mem_addr got=%h exp=0", bus.mem_addr); else n_pass++;
      n_checks++; if (bus.mem_wdata !== 32'h0) $display("FAIL rst_mem_wdata got=%h exp=0", bus.mem_wdata); else n_pass++;
      n_checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", bus.busy); else n_pass++;
      n_checks++; if (bus.done !== 1'b0) $display("FAIL rst_done got=%b exp=0", bus.done); else n_pass++;
      n_checks++; if (bus.err !== 1'b0) $display("FAIL rst_err got=%b exp=0", bus.err); else n_pass++;
      n_checks++; if (bus.cpu_rst !== 1'b1) $display("FAIL rst_cpu_rst got=%b exp=1", bus.cpu_rst); else n_pass++;
      rst = 1'b0;
      #1;
      n_checks++; if (bus.cpu_rst !== 1'b0) $display("FAIL post_rst_cpu_rst got=%b exp=0", bus.cpu_rst); else n_pass++;
   endtask

   task automatic test_single_word();
      bit ok;
      int base = got_q.size();
      tx_q.delete();
      tx_q.push_back(8'h12); tx_q.push_back(8'h34);
      tx_q.push_back(8'h56); tx_q.push_back(8'h78);
      start_load(1);
      send_bytes(0, 4, 0, ok);
      n_checks++; if (!ok) $display("FAIL single_byte_timeout got=stall exp=accept"); else n_pass++;
      wait_done(ok);
      n_checks++; if (!ok) $display("FAIL single_done_timeout got=none exp=done"); else n_pass++;
      n_checks++; if (bus.cpu_rst !== 1'b1) $display("FAIL single_cpu_rst_in_done got=%b exp=1", bus.cpu_rst); else n_pass++;
      #1;
      n_checks++; if (got_q.size() - base !== 1) $display("FAIL single_we_count got=%0d exp=1", got_q.size() - base); else n_pass++;
      if (got_q.size() > base) begin
         n_checks++; if (got_q[base] !== {32'h0, 32'h12345678}) $display("FAIL single_write got=%h exp=%h", got_q[base], {32'h0, 32'h12345678}); else n_pass++;
      end
      n_checks++; if (done_cyc - we_cyc !== 1) $display("FAIL single_done_latency got=%0d exp=1", done_cyc - we_cyc); else n_pass++;
      @(negedge clk);
      n_checks++; if (bus.cpu_rst !== 1'b0) $display("FAIL single_cpu_release got=%b exp=0", bus.cpu_rst); else n_pass++;
      n_checks++; if (bus.busy !== 1'b0) $display("FAIL single_busy_after got=%b exp=0", bus.busy); else n_pass++;
   endtask

   task automatic test_gapped_load(input int wc, input int gap_max, input string tag);
      bit ok;
      int base = got_q.size();
      int d0   = done_cnt;
      fill_tx(4 * wc);
      build_exp(wc);
      start_load(wc);
      send_bytes(0, 4 * wc, gap_max, ok);
      n_checks++; if (!ok) $display("FAIL %s_byte_timeout got=stall exp=accept", tag); else n_pass++;
      wait_done(ok);
      n_checks++; if (!ok) $display("FAIL %s_done_timeout got=none exp=done", tag); else n_pass++;
      @(negedge clk);
      #1;
      n_checks++; if (got_q.size() - base !== exp_q.size()) $display("FAIL %s_we_count got=%0d exp=%0d", tag, got_q.size() - base, exp_q.size()); else n_pass++;
      foreach (exp_q[i]) begin
         if (base + i < got_q.size()) begin
            n_checks++; if (got_q[base + i] !== exp_q[i]) $display("FAIL %s_write%0d got=%h exp=%h", tag, i, got_q[base + i], exp_q[i]); else n_pass++;
         end
      end
      n_checks++; if (done_cnt - d0 !== 1) $display("FAIL %s_done_pulses got=%0d exp=1", tag, done_cnt - d0); else n_pass++;
   endtask

   task automatic test_reject();
      int base = got_q.size();
      int e0   = err_cnt;
      int bad[2];
      bad[0] = 0;
      bad[1] = DEPTH + 1;
      foreach (bad[k]) begin
         start_load(bad[k]);
         n_checks++; if (bus.err !== 1'b1) $display("FAIL reject%0d_err got=%b exp=1", bad[k], bus.err); else n_pass++;
         n_checks++; if (bus.busy !== 1'b0) $display("FAIL reject%0d_busy got=%b exp=0", bad[k], bus.busy); else n_pass++;
         n_checks++; if (bus.byte_ready !== 1'b0) $display("FAIL reject%0d_ready got=%b exp=0", bad[k], bus.byte_ready); else n_pass++;
         @(posedge clk);
         #1;
         n_checks++; if (bus.err !== 1'b0) $display("FAIL reject%0d_err_width got=%b exp=0", bad[k], bus.err); else n_pass++;
         n_checks++; if (bus.byte_ready !== 1'b0) $display("FAIL reject%0d_ready_later got=%b exp=0", bad[k], bus.byte_ready); else n_pass++;
      end
      @(negedge clk);
      #1;
      n_checks++; if (err_cnt - e0 !== 2) $display("FAIL reject_err_pulses got=%0d exp=2", err_cnt - e0); else n_pass++;
      n_checks++; if (got_q.size() - base !== 0) $display("FAIL reject_we got=%0d exp=0", got_q.size() - base); else n_pass++;
   endtask

   task automatic test_restart_ignored();
      bit ok;
      int base = got_q.size();
      int e0   = err_cnt;
      fill_tx(8);
      build_exp(2);
      start_load(2);
      send_bytes(0, 2, 1, ok);
      start_load(1);
      send_bytes(2, 6, 1, ok);
      n_checks++; if (!ok) $display("FAIL restart_byte_timeout got=stall exp=accept"); else n_pass++;
      wait_done(ok);
      n_checks++; if (!ok) $display("FAIL restart_done_timeout got=none exp=done"); else n_pass++;
      @(negedge clk);
      #1;
      n_checks++; if (got_q.size() - base !== 2) $display("FAIL restart_we_count got=%0d exp=2", got_q.size() - base); else n_pass++;
      foreach (exp_q[i]) begin
         if (base + i < got_q.size()) begin
            n_checks++; if (got_q[base + i] !== exp_q[i]) $display("FAIL restart_write%0d got=%h exp=%h", i, got_q[base + i], exp_q[i]); else n_pass++;
         end
      end
      n_checks++; if (err_cnt !== e0) $display("FAIL restart_err got=%0d exp=%0d", err_cnt, e0); else n_pass++;
   endtask

   task automatic test_reset_midload();
      bit ok;
      int base = got_q.size();
      fill_tx(8);
      start_load(2);
      send_bytes(0, 2, 0, ok);
      #3;
      rst = 1'b1;
      #1;
      n_checks++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", bus.busy); else n_pass++;
      n_checks++; if (bus.byte_ready !== 1'b0) $display("FAIL midrst_ready got=%b exp=0", bus.byte_ready); else n_pass++;
      n_checks++; if (bus.cpu_rst !== 1'b1) $display("FAIL midrst_cpu_rst got=%b exp=1", bus.cpu_rst); else n_pass++;
      n_checks++; if (bus.mem_wdata !== 32'h0) $display("FAIL midrst_wdata got=%h exp=0", bus.mem_wdata); else n_pass++;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (got_q.size() - base !== 0) $display("FAIL midrst_we got=%0d exp=0", got_q.size() - base); else n_pass++;
      test_gapped_load(1, 1, "after_rst");
   endtask

   task automatic test_full_depth();
      bit ok;
      int base = got_q.size();
      int t0;
      fill_tx(4 * DEPTH);
      build_exp(DEPTH);
      start_load(DEPTH);
      t0 = cyc + 1;
      n_checks++; if (bus.byte_ready !== 1'b1) $display("FAIL full_first_recv got=%b exp=1", bus.byte_ready); else n_pass++;
      send_bytes(0, 4 * DEPTH, 0, ok);
      n_checks++; if (!ok) $display("FAIL full_byte_timeout got=stall exp=accept"); else n_pass++;
      wait_done(ok);
      n_checks++; if (!ok) $display("FAIL full_done_timeout got=none exp=done"); else n_pass++;
      #1;
      // Counted inclusively: first RECV cycle is cycle 1, done lands on 5N+1.
      n_checks++; if (done_cyc - t0 + 1 !== 5 * DEPTH + 1) $display("FAIL full_latency got=%0d exp=%0d", done_cyc - t0 + 1, 5 * DEPTH + 1); else n_pass++;
      n_checks++; if (got_q.size() - base !== DEPTH) $display("FAIL full_we_count got=%0d exp=%0d", got_q.size() - base, DEPTH); else n_pass++;
      foreach (exp_q[i]) begin
         if (base + i < got_q.size()) begin
            n_checks++; if (got_q[base + i] !== exp_q[i]) $display("FAIL full_write%0d got=%h exp=%h", i, got_q[base + i], exp_q[i]); else n_pass++;
         end
      end
      if (got_q.size() >= base + DEPTH) begin
         n_checks++; if (got_q[base + DEPTH - 1][63:32] !== 32'(4 * (DEPTH - 1))) $display("FAIL full_last_addr got=%h exp=%h", got_q[base + DEPTH - 1][63:32], 32'(4 * (DEPTH - 1))); else n_pass++;
      end
      @(negedge clk);
   endtask

   task automatic test_random_loads();
      for (int r = 0; r < 4; r++) test_gapped_load($urandom_range(1, DEPTH), 3, "rand");
      n_checks++; if (ready_in_we !== 0) $display("FAIL ready_during_we got=%0d exp=0", ready_in_we); else n_pass++;
   endtask

   initial begin
      bus.start      = 1'b0;
      bus.word_count = '0;
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'h00;
      test_reset();
      test_single_word();
      test_gapped_load(3, 3, "gaps3");
      test_reject();
      test_restart_ignored();
      test_reset_midload();
      test_full_depth();
      test_random_loads();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
